// File: rtl/a2d_pkg.sv
// Shared A2D bus definitions: channel type, channel map and frame length.
package a2d_pkg;

   typedef logic [2:0] a2d_chan_t;

   localparam a2d_chan_t CH_LD_LFT  = 3'd0;
   localparam a2d_chan_t CH_LD_RGHT = 3'd4;
   localparam a2d_chan_t CH_STEER   = 3'd5;
   localparam a2d_chan_t CH_BATT    = 3'd6;

   localparam int unsigned A2D_FRAME_BITS = 16;

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } a2d_state_e;

endpackage

// File: rtl/a2d_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with one extra flop
// providing single-clk rise/fall strobes on the synchronized level.
module a2d_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/a2d_spi_resp.sv
// ADC128S-style SPI responder: returns the channel addressed in the previous
// frame. Define ADC_RESP_CHK_EN to build the sticky protocol-error checker.
module a2d_spi_resp
   import a2d_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   input  logic [11:0] ld_cell_lft,
   input  logic [11:0] ld_cell_rght,
   input  logic [11:0] steerPot,
   input  logic [11:0] batt,
   output logic        frm_done,
   output logic        err
);

   localparam logic [4:0] FRAME_CNT = 5'(A2D_FRAME_BITS);

   logic ss_rise, ss_fall, sclk_rise, sclk_fall;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic mosi_s;

   a2d_state_e state_q, state_d;
   logic [15:0] tx_shft_q, tx_shft_d;
   // Only bits [13:11] of the received word are ever used, so the upper two
   // positions of the 16-bit shift register are never stored.
   logic [13:0] rx_shft_q, rx_shft_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   a2d_chan_t   cur_chan_q, cur_chan_d;
   logic        frm_done_q, frm_done_d;
   logic [11:0] chan_val;

   a2d_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (SS_n),
      .rise (ss_rise),
      .fall (ss_fall)
   );

   a2d_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (SCLK),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   always_comb begin
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
   end

   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   always_comb begin
      chan_val = '0;
      case (cur_chan_q)
         CH_LD_LFT:  chan_val = ld_cell_lft;
         CH_LD_RGHT: chan_val = ld_cell_rght;
         CH_STEER:   chan_val = steerPot;
         CH_BATT:    chan_val = batt;
         default:    chan_val = '0;
      endcase
   end

`ifdef ADC_RESP_CHK_EN
   logic err_q, err_d, err_set;
`endif

   always_comb begin
      state_d    = state_q;
      tx_shft_d  = tx_shft_q;
      rx_shft_d  = rx_shft_q;
      bit_cnt_d  = bit_cnt_q;
      cur_chan_d = cur_chan_q;
      frm_done_d = 1'b0;
`ifdef ADC_RESP_CHK_EN
      err_set    = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (ss_fall) begin
               tx_shft_d = {4'h0, chan_val};
               rx_shft_d = '0;
               bit_cnt_d = '0;
               state_d   = ST_SHIFT;
            end
`ifdef ADC_RESP_CHK_EN
            else if (sclk_rise || sclk_fall) begin
               err_set = 1'b1;
            end
`endif
         end
         ST_SHIFT: begin
            if (ss_rise) begin
               if (bit_cnt_q == FRAME_CNT) begin
                  cur_chan_d = rx_shft_q[13:11];
                  frm_done_d = 1'b1;
               end
`ifdef ADC_RESP_CHK_EN
               else begin
                  err_set = 1'b1;
               end
`endif
               state_d = ST_IDLE;
            end else if (!ss_fall) begin
               if (sclk_rise) begin
                  rx_shft_d = {rx_shft_q[12:0], mosi_s};
                  if (bit_cnt_q != 5'd31) begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end else if (sclk_fall && (bit_cnt_q != 5'd0)) begin
                  tx_shft_d = {tx_shft_q[14:0], 1'b0};
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mosi_sync_q <= '0;
         state_q     <= ST_IDLE;
         tx_shft_q   <= '0;
         rx_shft_q   <= '0;
         bit_cnt_q   <= '0;
         cur_chan_q  <= CH_LD_LFT;
         frm_done_q  <= 1'b0;
      end else begin
         mosi_sync_q <= mosi_sync_d;
         state_q     <= state_d;
         tx_shft_q   <= tx_shft_d;
         rx_shft_q   <= rx_shft_d;
         bit_cnt_q   <= bit_cnt_d;
         cur_chan_q  <= cur_chan_d;
         frm_done_q  <= frm_done_d;
      end
   end

`ifdef ADC_RESP_CHK_EN
   always_comb begin
      err_d = err_q | err_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign MISO     = (state_q == ST_SHIFT) & tx_shft_q[15];
   assign frm_done = frm_done_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Scoreboard bench for a2d_spi_resp: drives SPI frames at clk/32 and checks
// returned words, frm_done timing and the err flag.
module tb_a2d_spi_resp;

   logic        clk = 1'b0;
   logic        rst_n, SS_n, SCLK, MOSI;
   logic        MISO, frm_done, err;
   logic [11:0] ld_cell_lft, ld_cell_rght, steerPot, batt;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] sb_q[$];

`ifdef ADC_RESP_CHK_EN
   localparam logic CHK_BUILD = 1'b1;
`else
   localparam logic CHK_BUILD = 1'b0;
`endif

   a2d_spi_resp #(.SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .SS_n        (SS_n),
      .SCLK        (SCLK),
      .MOSI        (MOSI),
      .MISO        (MISO),
      .ld_cell_lft (ld_cell_lft),
      .ld_cell_rght(ld_cell_rght),
      .steerPot    (steerPot),
      .batt        (batt),
      .frm_done    (frm_done),
      .err         (err)
   );

   always #10 clk = ~clk;

   task automatic spi_frame(input logic [15:0] cmd, input int unsigned nbits,
                            input bit exp_done, input bit chk_miso);
      logic [15:0] rx;
      logic [15:0] exp;
      logic [3:0]  done_s;
      logic [3:0]  done_exp;
      rx = '0;
      done_s = '0;
      @(negedge clk);
      SS_n = 1'b0;
      repeat (16) @(negedge clk);
      for (int unsigned i = 0; i < nbits; i++) begin
         SCLK = 1'b0;
         MOSI = cmd[15-i];
         repeat (16) @(negedge clk);
         rx   = {rx[14:0], MISO};
         SCLK = 1'b1;
         repeat (16) @(negedge clk);
      end
      SS_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         done_s[3-k] = frm_done;
      end
      done_exp = exp_done ? 4'b0010 : 4'b0000;
      checks++;
      if (done_s !== done_exp) begin
         failures++;
         $display("FAIL frm_done_timing cmd=%h got=%b want=%b", cmd, done_s, done_exp);
      end
      if (chk_miso) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty cmd=%h got=%h want=<none>", cmd, rx);
         end else begin
            exp = sb_q.pop_front();
            if (rx !== exp) begin
               failures++;
               $display("FAIL miso_word cmd=%h got=%h want=%h", cmd, rx, exp);
            end
         end
      end
      repeat (16) @(negedge clk);
   endtask

   task automatic check_err(input string name, input logic exp);
      checks++;
      if (err !== exp) begin
         failures++;
         $display("FAIL %s got=%b want=%b", name, err, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      SS_n = 1'b1;
      SCLK = 1'b1;
      MOSI = 1'b0;
      ld_cell_lft  = 12'h300;
      ld_cell_rght = 12'h0C3;
      steerPot     = 12'hE00;
      batt         = 12'h5A5;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (MISO !== 1'b0) begin
         failures++;
         $display("FAIL reset_miso got=%b want=0", MISO);
      end
      checks++;
      if (frm_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_frm_done got=%b want=0", frm_done);
      end
      check_err("reset_err", 1'b0);
      sb_q.push_back(16'h0300);
      spi_frame(16'h0000, 16, 1'b1, 1'b1);
   endtask

   task automatic test_chan_select();
      sb_q.push_back(16'h0300);
      spi_frame(16'h2800, 16, 1'b1, 1'b1);
      sb_q.push_back(16'h0E00);
      spi_frame(16'h0800, 16, 1'b1, 1'b1);
   endtask

   task automatic test_unused_chan();
      sb_q.push_back(16'h0000);
      spi_frame(16'h2800, 16, 1'b1, 1'b1);
   endtask

   task automatic test_snapshot();
      sb_q.push_back(16'h0E00);
      fork
         spi_frame(16'h2800, 16, 1'b1, 1'b1);
         begin
            repeat (60) @(negedge clk);
            steerPot = 12'h200;
         end
      join
      sb_q.push_back(16'h0200);
      spi_frame(16'h2800, 16, 1'b1, 1'b1);
   endtask

   task automatic test_short_frame();
      spi_frame(16'h3000, 8, 1'b0, 1'b0);
      check_err("short_frame_err", CHK_BUILD);
      sb_q.push_back(16'h0200);
      spi_frame(16'h2800, 16, 1'b1, 1'b1);
      check_err("short_frame_err_sticky", CHK_BUILD);
   endtask

   task automatic test_back_to_back();
      logic [15:0] cmds [6];
      logic [15:0] exps [6];
      cmds = '{16'h2000, 16'h3000, 16'h1800, 16'h0000, 16'h3800, 16'h2000};
      exps = '{16'h0200, 16'h00C3, 16'h05A5, 16'h0000, 16'h0300, 16'h0000};
      for (int i = 0; i < 6; i++) begin
         sb_q.push_back(exps[i]);
         spi_frame(cmds[i], 16, 1'b1, 1'b1);
      end
   endtask

   task automatic test_reset_midframe();
      ld_cell_rght = 12'hFAB;
      ld_cell_lft  = 12'h123;
      @(negedge clk);
      SS_n = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         SCLK = 1'b0;
         MOSI = 1'b0;
         repeat (16) @(negedge clk);
         SCLK = 1'b1;
         repeat (16) @(negedge clk);
      end
      checks++;
      if (MISO !== 1'b1) begin
         failures++;
         $display("FAIL midframe_miso_bit8 got=%b want=1", MISO);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (MISO !== 1'b0) begin
         failures++;
         $display("FAIL reset_midframe_miso got=%b want=0", MISO);
      end
      SS_n = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_err("reset_midframe_err", 1'b0);
      sb_q.push_back(16'h0123);
      spi_frame(16'h0000, 16, 1'b1, 1'b1);
   endtask

   task automatic test_idle_sclk();
      @(negedge clk);
      SCLK = 1'b0;
      repeat (16) @(negedge clk);
      SCLK = 1'b1;
      repeat (16) @(negedge clk);
      check_err("idle_sclk_err", CHK_BUILD);
   endtask

   initial begin
      test_reset();
      test_chan_select();
      test_unused_chan();
      test_snapshot();
      test_short_frame();
      test_back_to_back();
      test_reset_midframe();
      test_idle_sclk();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
